// File: rtl/gate_pkg.sv
// Shared types and constants for the garage gate controller.
package gate_pkg;

  // Controller phase: waiting for a request, or animating a movement.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ENTER = 2'b01,
    ST_EXIT  = 2'b10
  } state_e;

  // Gate animation codes driven on `moving`.
  localparam logic [1:0] MOV_NONE = 2'b00;
  localparam logic [1:0] MOV_IN   = 2'b01;
  localparam logic [1:0] MOV_OUT  = 2'b10;

  // Bit positions inside the `pressed` request vector.
  localparam int PRESS_EXIT  = 1;
  localparam int PRESS_ENTER = 0;

endpackage

// File: rtl/gate_timer.sv
// Loadable 8-bit down-counter that times one gate movement phase.
// `done` is high during the final cycle of a running phase (count == 0).
module gate_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] count_r;
  logic       running_r;

  // Load on request, otherwise count down to zero and then stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= 8'd0;
      running_r <= 1'b0;
    end else if (load) begin
      count_r   <= load_val;
      running_r <= 1'b1;
    end else if (running_r) begin
      if (count_r == 8'd0) begin
        running_r <= 1'b0;
      end else begin
        count_r <= count_r - 8'd1;
      end
    end else begin
      count_r   <= count_r;
      running_r <= running_r;
    end
  end

  assign done = running_r && (count_r == 8'd0);

endmodule

// File: rtl/gate_ctrl.sv
// Garage occupancy and gate-sequencing controller. Accepts one car movement
// at a time, animates it for GATE_TICKS cycles, then commits the count change.
module gate_ctrl
  import gate_pkg::*;
#(
  parameter int CAPACITY   = 9,
  parameter int GATE_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pressed,
  output logic [3:0] remain,
  output logic [1:0] moving,
  output logic       full,
  output logic       denied
);

  localparam logic [3:0] CAP_VAL  = 4'(CAPACITY);
  localparam logic [7:0] LOAD_VAL = 8'(GATE_TICKS - 1);

  state_e     state_r;
  state_e     state_next_s;
  logic [3:0] remain_r;
  logic [3:0] remain_next_s;
  logic [1:0] moving_r;
  logic [1:0] moving_next_s;
  logic       full_r;
  logic       denied_r;
  logic       denied_next_s;
  logic       load_s;
  logic       done_s;
  logic       enter_req_s;
  logic       exit_req_s;

  // A simultaneous enter+exit is a net-zero event, so only single requests count.
  assign enter_req_s = pressed[PRESS_ENTER] & ~pressed[PRESS_EXIT];
  assign exit_req_s  = pressed[PRESS_EXIT]  & ~pressed[PRESS_ENTER];

  gate_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (LOAD_VAL),
    .done     (done_s)
  );

  // Next-state, next-count and denial decision for the current cycle.
  always_comb begin
    state_next_s  = state_r;
    remain_next_s = remain_r;
    denied_next_s = 1'b0;
    load_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enter_req_s) begin
          if (remain_r != 4'd0) begin
            state_next_s = ST_ENTER;
            load_s       = 1'b1;
          end else begin
            denied_next_s = 1'b1;
          end
        end else if (exit_req_s) begin
          if (remain_r < CAP_VAL) begin
            state_next_s = ST_EXIT;
            load_s       = 1'b1;
          end else begin
            denied_next_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ENTER: begin
        // Requests during a phase are dropped; only the timer matters here.
        if (done_s) begin
          remain_next_s = remain_r - 4'd1;
          state_next_s  = ST_IDLE;
        end else begin
          state_next_s = ST_ENTER;
        end
      end
      ST_EXIT: begin
        if (done_s) begin
          remain_next_s = remain_r + 4'd1;
          state_next_s  = ST_IDLE;
        end else begin
          state_next_s = ST_EXIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Animation code follows the state being entered, so it lands on the same edge.
  always_comb begin
    moving_next_s = MOV_NONE;
    case (state_next_s)
      ST_ENTER: moving_next_s = MOV_IN;
      ST_EXIT:  moving_next_s = MOV_OUT;
      ST_IDLE:  moving_next_s = MOV_NONE;
      default:  moving_next_s = MOV_NONE;
    endcase
  end

  // State, count and all output flops; reset aborts any phase without commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      remain_r <= CAP_VAL;
      moving_r <= MOV_NONE;
      full_r   <= 1'b0;
      denied_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      remain_r <= remain_next_s;
      moving_r <= moving_next_s;
      full_r   <= (remain_next_s == 4'd0);
      denied_r <= denied_next_s;
    end
  end

  assign remain = remain_r;
  assign moving = moving_r;
  assign full   = full_r;
  assign denied = denied_r;

endmodule
